// File: rtl/sdram_arbit.sv
// sdram_arbit: command arbiter and auto-refresh scheduler for the SDRAM
// controller. Grants the bus to the init, write or read sequencer, issues
// AUTO REFRESH on its own timer, and muxes the granted sequencer onto the pins.
// Optional build macro: ARBIT_FAIR_EN (reads win the arbitration that
// directly follows a write service; refresh always stays highest).
module sdram_arbit #(
  parameter int REF_PERIOD = 750,
  parameter int TRC_CYC    = 7
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        rd_en,
  output logic        ref_req,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_bank
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int TMR_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int CNT_W = (TRC_CYC > 1) ? $clog2(TRC_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRC_CYC - 1);

  typedef enum logic [2:0] {S_INIT, S_ARBIT, S_AREF, S_WR, S_RD} state_t;

  state_t           state;
  logic [TMR_W-1:0] ref_tmr;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_enter;
`ifdef ARBIT_FAIR_EN
  logic             wr_last;  // last completed service was a write
`endif

  // A refresh is entered exactly when arbitration sees a pending refresh.
  assign ref_enter = (state == S_ARBIT) && ref_req;

  // Main FSM: init hand-off, arbitration, refresh occupancy and bus release.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state   <= S_INIT;
      ref_cnt <= '0;
`ifdef ARBIT_FAIR_EN
      wr_last <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT: if (init_end) state <= S_ARBIT;
        S_ARBIT: begin
          ref_cnt <= '0;
          if (ref_req) state <= S_AREF;
`ifdef ARBIT_FAIR_EN
          else if (rd_req && (wr_last || !wr_req)) state <= S_RD;
          else if (wr_req) state <= S_WR;
`else
          else if (wr_req) state <= S_WR;
          else if (rd_req) state <= S_RD;
`endif
        end
        S_AREF: begin
          if (ref_cnt == CNT_LAST) begin
            ref_cnt <= '0;
            state   <= S_ARBIT;
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        S_WR: if (wr_end) begin
          state <= S_ARBIT;
`ifdef ARBIT_FAIR_EN
          wr_last <= 1'b1;
`endif
        end
        S_RD: if (rd_end) begin
          state <= S_ARBIT;
`ifdef ARBIT_FAIR_EN
          wr_last <= 1'b0;
`endif
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Free-running refresh timer; its wrap raises ref_req, which is cleared
  // when the refresh starts unless a new wrap lands on the same cycle.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      ref_tmr <= '0;
      ref_req <= 1'b0;
    end else if (state == S_INIT) begin
      ref_tmr <= '0;
      ref_req <= 1'b0;
    end else begin
      if (ref_tmr == TMR_LAST) begin
        ref_tmr <= '0;
        ref_req <= 1'b1;
      end else begin
        ref_tmr <= ref_tmr + 1'b1;
        if (ref_enter) ref_req <= 1'b0;
      end
    end
  end

  // Grants are pure decodes of the state register.
  assign wr_en = (state == S_WR);
  assign rd_en = (state == S_RD);

  // Pin mux: zero-latency pass-through of the granted sequencer.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = '0;
    case (state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_WR: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      S_RD: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      S_AREF: sdram_cmd = (ref_cnt == '0) ? CMD_AREF : CMD_NOP;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: randomized scoreboard bench for sdram_arbit. A behavioural
// model predicts every cycle's pin/grant values and queues them; a monitor
// on the falling edge pops and compares. Honors ARBIT_FAIR_EN if defined.
module tb_sdram_arbit;

  localparam int REF_PERIOD = 750;
  localparam int TRC_CYC    = 7;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] AREF = 4'b0001;
`ifdef ARBIT_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        s_rst, init_end;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic        wr_req, wr_end, rd_req, rd_end;
  logic [3:0]  wr_cmd, rd_cmd;
  logic [12:0] wr_addr, rd_addr;
  logic [1:0]  wr_bank, rd_bank;
  logic        wr_en, rd_en, ref_req;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank;

  always #5 sclk = ~sclk;

  sdram_arbit #(.REF_PERIOD(REF_PERIOD), .TRC_CYC(TRC_CYC)) dut (
    .sclk(sclk), .s_rst(s_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_addr(init_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_bank(wr_bank), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .rd_en(rd_en),
    .ref_req(ref_req), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank)
  );

  typedef struct packed {
    logic        wr_en;
    logic        rd_en;
    logic        ref_req;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  bank;
  } exp_t;

  typedef enum int {O_INIT, O_IDLE, O_WR, O_RD, O_REF} owner_t;

  exp_t   exp_q[$];
  int     tests = 0;
  int     fails = 0;
  int     pushed = 0;
  int     popped = 0;

  // Behavioural model: who owns the bus, refresh pending, cycles since init.
  owner_t m_owner = O_INIT;
  bit     m_pend  = 1'b0;
  int     m_run   = 0;
  int     m_age   = 0;
  bit     m_last_wr = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Predict this cycle's outputs, queue them, then advance the model one edge.
  task automatic step(bit chk);
    exp_t   e;
    owner_t nxt;
    bit     set, clr, rd_first;
    if (chk) begin
      e = '0;
      e.ref_req = m_pend;
      case (m_owner)
        O_INIT: begin e.cmd = init_cmd; e.addr = init_addr; end
        O_IDLE: e.cmd = NOP;
        O_WR:   begin e.wr_en = 1'b1; e.cmd = wr_cmd; e.addr = wr_addr; e.bank = wr_bank; end
        O_RD:   begin e.rd_en = 1'b1; e.cmd = rd_cmd; e.addr = rd_addr; e.bank = rd_bank; end
        O_REF:  e.cmd = (m_age == 0) ? AREF : NOP;
        default: e.cmd = NOP;
      endcase
      exp_q.push_back(e);
      pushed++;
    end
    if (s_rst) begin
      m_owner = O_INIT; m_pend = 1'b0; m_run = 0; m_age = 0; m_last_wr = 1'b0;
    end else begin
      set = (m_owner != O_INIT) && (((m_run + 1) % REF_PERIOD) == 0);
      clr = 1'b0;
      nxt = m_owner;
      case (m_owner)
        O_INIT: if (init_end) nxt = O_IDLE;
        O_IDLE: begin
          if (m_pend) begin
            nxt = O_REF; m_age = 0; clr = 1'b1;
          end else begin
            rd_first = FAIR && m_last_wr;
            if (wr_req && !(rd_first && rd_req)) nxt = O_WR;
            else if (rd_req) nxt = O_RD;
          end
        end
        O_WR: if (wr_end) begin nxt = O_IDLE; m_last_wr = 1'b1; end
        O_RD: if (rd_end) begin nxt = O_IDLE; m_last_wr = 1'b0; end
        O_REF: if (m_age == TRC_CYC - 1) nxt = O_IDLE; else m_age++;
        default: nxt = O_INIT;
      endcase
      m_run   = (m_owner != O_INIT) ? m_run + 1 : 0;
      m_pend  = set || (m_pend && !clr);
      m_owner = nxt;
    end
    @(posedge sclk);
    #1;
  endtask

  // Monitor: compares the queued prediction on every falling edge.
  always @(negedge sclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      popped++;
      check("wr_en",   32'(wr_en),      32'(e.wr_en));
      check("rd_en",   32'(rd_en),      32'(e.rd_en));
      check("ref_req", 32'(ref_req),    32'(e.ref_req));
      check("cmd",     32'(sdram_cmd),  32'(e.cmd));
      check("addr",    32'(sdram_addr), 32'(e.addr));
      check("bank",    32'(sdram_bank), 32'(e.bank));
    end
  end

  // Randomize sequencer data buses and (optionally) stray end pulses.
  task automatic rand_data(int end_pct);
    init_addr = 13'($urandom);
    wr_cmd  = 4'($urandom); wr_addr = 13'($urandom); wr_bank = 2'($urandom);
    rd_cmd  = 4'($urandom); rd_addr = 13'($urandom); rd_bank = 2'($urandom);
    wr_end  = ($urandom_range(0, 99) < end_pct);
    rd_end  = ($urandom_range(0, 99) < end_pct);
  endtask

  task automatic run(int n, int wr_pct, int rd_pct, int end_pct);
    for (int i = 0; i < n; i++) begin
      rand_data(end_pct);
      wr_req = ($urandom_range(0, 99) < wr_pct);
      rd_req = ($urandom_range(0, 99) < rd_pct);
      step(1'b1);
    end
  endtask

  task automatic do_init();
    init_end = 1'b0;
    init_cmd = 4'b0010;
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_data(0);
      step(1'b1);
    end
    init_end = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    s_rst = 1'b1; init_end = 1'b0; init_cmd = 4'b0010;
    wr_req = 1'b0; rd_req = 1'b0;
    rand_data(0);
    #1;
    step(1'b0);                       // DUT state unknown before first edge
    step(1'b1);
    s_rst = 1'b0;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_ref_req", 32'(ref_req), 32'd0);
    check("rst_cmd", 32'(sdram_cmd), 32'(init_cmd));

    do_init();
    run(1600, 0, 0, 5);               // idle refreshes, stray ends ignored
    run(600, 0, 100, 10);             // read grants, some spanning refresh
    run(1600, 100, 100, 12);          // simultaneous requests held
    run(2000, 50, 50, 15);            // fully random mix

    // Reset in the middle of a write burst.
    waited = 0;
    wr_req = 1'b1; rd_req = 1'b0;
    while (m_owner != O_WR && waited < 200) begin
      rand_data(0);
      step(1'b1);
      waited++;
    end
    check("wait_wr_grant", 32'(m_owner == O_WR), 32'd1);
    rand_data(0);
    s_rst = 1'b1;
    step(1'b1);
    s_rst = 1'b0;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_ref_req", 32'(ref_req), 32'd0);
    check("midrst_cmd", 32'(sdram_cmd), 32'(init_cmd));
    do_init();
    run(1200, 60, 60, 15);

    wr_req = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge sclk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("pop_count", 32'(popped), 32'(pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
